// File: rtl/z_mem_sched_pkg.sv
// Shared types for the Z_j store access scheduler: pass FSM states and
// memory-port grant codes.
package z_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } gnt_e;

endpackage

// File: rtl/z_mem_sched_if.sv
// Writer, consumer and memory-port signals of the Z_j scheduler.
// master = the scheduler, slave = its environment (MAC writer, normaliser, RAM).
interface z_mem_sched_if #(
  parameter int PROD_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);

  logic                  wr_valid;
  logic [PROD_WIDTH-1:0] wr_data;
  logic                  wr_ready;

  logic                  rd_out_valid;
  logic [PROD_WIDTH-1:0] rd_out_data;
  logic [ADDR_WIDTH-1:0] rd_out_idx;
  logic                  rd_out_ready;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [PROD_WIDTH-1:0] mem_wdata;
  logic                  mem_rw_;
  logic [PROD_WIDTH-1:0] mem_rdata;

  modport master (
    input  wr_valid, wr_data, rd_out_ready, mem_rdata,
    output wr_ready, rd_out_valid, rd_out_data, rd_out_idx,
           mem_addr, mem_wdata, mem_rw_
  );

  modport slave (
    output wr_valid, wr_data, rd_out_ready, mem_rdata,
    input  wr_ready, rd_out_valid, rd_out_data, rd_out_idx,
           mem_addr, mem_wdata, mem_rw_
  );

endinterface

// File: rtl/z_mem_sched_arb.sv
// Two-requester round-robin arbiter (writer vs reader) for the single Z_j port.
// On a tie the client that did not win last time is granted.
module z_rr_arb2
  import z_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_wr,
  input  logic req_rd,
  output gnt_e gnt
);

  gnt_e last_grant;

  always_comb begin
    gnt = GNT_NONE;
    if (req_wr && req_rd) gnt = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
    else if (req_wr)      gnt = GNT_WR;
    else if (req_rd)      gnt = GNT_RD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   last_grant <= GNT_RD;
    else if (gnt != GNT_NONE)  last_grant <= gnt;
  end

endmodule

// File: rtl/z_mem_sched.sv
// Z_j store scheduler: one pass of N queries per start, MAC writes in order,
// normaliser reads in order through a valid/ready output register.
module z_mem_sched
  import z_sched_pkg::*;
#(
  parameter int PROD_WIDTH      = 16,
  parameter int MAX_NUM_QUERIES = 256,
  parameter int ADDR_WIDTH      = $clog2(MAX_NUM_QUERIES)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_WIDTH:0] num_queries,
  output logic                busy,
  output logic                done,
  z_mem_sched_if.master       bus
);

  localparam logic [ADDR_WIDTH:0] MAXQ = (ADDR_WIDTH+1)'(MAX_NUM_QUERIES);

  state_e              state;
  // one extra bit so N == MAX_NUM_QUERIES is reachable without wrapping
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] n_reg;
  logic [ADDR_WIDTH:0] n_clamp;
  logic                out_free;
  logic                wr_elig;
  logic                rd_elig;
  logic                pass_end;
  gnt_e                gnt;

  always_comb begin
    n_clamp  = (num_queries > MAXQ) ? MAXQ : num_queries;
    out_free = !bus.rd_out_valid || bus.rd_out_ready;
    wr_elig  = (state == RUN) && bus.wr_valid && (wr_ptr < n_reg);
    // only entries already written may be read back
    rd_elig  = (state == RUN) && (rd_ptr < wr_ptr) && out_free;
    pass_end = (wr_ptr == n_reg) && (rd_ptr == n_reg) && out_free;
  end

  z_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_wr (wr_elig),
    .req_rd (rd_elig),
    .gnt    (gnt)
  );

  // Port mux: idle port parks on a read of rd_ptr with zero write data.
  always_comb begin
    bus.wr_ready  = (gnt == GNT_WR);
    bus.mem_rw_   = (gnt != GNT_WR);
    bus.mem_addr  = (gnt == GNT_WR) ? wr_ptr[ADDR_WIDTH-1:0] : rd_ptr[ADDR_WIDTH-1:0];
    bus.mem_wdata = (gnt == GNT_WR) ? bus.wr_data : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      n_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_reg  <= n_clamp;
            wr_ptr <= '0;
            rd_ptr <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (gnt == GNT_WR) wr_ptr <= wr_ptr + 1'b1;
          if (gnt == GNT_RD) rd_ptr <= rd_ptr + 1'b1;
          if (pass_end) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: refill on a read grant, which may coincide with an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_out_valid <= 1'b0;
      bus.rd_out_data  <= '0;
      bus.rd_out_idx   <= '0;
    end else if (gnt == GNT_RD) begin
      bus.rd_out_valid <= 1'b1;
      bus.rd_out_data  <= bus.mem_rdata;
      bus.rd_out_idx   <= rd_ptr[ADDR_WIDTH-1:0];
    end else if (bus.rd_out_ready) begin
      bus.rd_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_z_mem_sched.sv
// Scoreboard bench for z_mem_sched: accepted writes push expected (idx,data),
// consumer accepts collect observed (idx,data); each scenario task compares.
module tb_z_mem_sched;
  import z_sched_pkg::*;

  localparam int PW   = 16;
  localparam int MAXQ = 256;
  localparam int AW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_queries = '0;
  logic          busy;
  logic          done;

  z_mem_sched_if #(.PROD_WIDTH(PW), .ADDR_WIDTH(AW)) zif ();

  z_mem_sched #(.PROD_WIDTH(PW), .MAX_NUM_QUERIES(MAXQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_queries (num_queries),
    .busy        (busy),
    .done        (done),
    .bus         (zif.master)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] mem [MAXQ];
  always @(posedge clk) if (!zif.mem_rw_) mem[zif.mem_addr] <= zif.mem_wdata;
  assign zif.mem_rdata = mem[zif.mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+PW-1:0] exp_q[$];
  logic [AW+PW-1:0] got_q[$];
  int gnt_hist[$];

  int      widx, feed_n, seed;
  bit      feed_en, rdy;
  bit      w_fire, o_fire, r_gnt, rw_s, done_s, busy_s;
  logic [PW-1:0] data_s;

  function automatic logic [PW-1:0] zval(int i);
    if (seed == 0) return PW'(10 * (i + 1));
    return PW'(i * 7 + seed);
  endfunction

  // One clock: drive writer/consumer, sample mid-low phase, observe after edge.
  task automatic tick();
    bit pre_v;
    zif.wr_valid     = feed_en && (widx < feed_n);
    zif.wr_data      = zval(widx);
    zif.rd_out_ready = rdy;
    #2;
    w_fire = zif.wr_valid && zif.wr_ready;
    o_fire = zif.rd_out_valid && zif.rd_out_ready;
    pre_v  = zif.rd_out_valid;
    rw_s   = zif.mem_rw_;
    done_s = done;
    busy_s = busy;
    data_s = zif.rd_out_data;
    if (w_fire) begin
      exp_q.push_back({AW'(widx), zval(widx)});
      widx++;
    end
    if (o_fire) got_q.push_back({zif.rd_out_idx, zif.rd_out_data});
    @(posedge clk);
    #1;
    r_gnt = zif.rd_out_valid && (!pre_v || o_fire);
    gnt_hist.push_back(!rw_s ? 1 : (r_gnt ? 2 : 0));
    @(negedge clk);
  endtask

  task automatic start_pass(int n);
    exp_q.delete();
    got_q.delete();
    gnt_hist.delete();
    widx = 0;
    num_queries = (AW+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    gnt_hist.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    zif.wr_valid = 1'b1;
    zif.wr_data = 16'h1234;
    zif.rd_out_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (zif.rd_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", zif.rd_out_valid); end
    n_checks++; if (zif.rd_out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", zif.rd_out_data); end
    n_checks++; if (zif.rd_out_idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0h expected 0", zif.rd_out_idx); end
    n_checks++; if (zif.wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %0b expected 0", zif.wr_ready); end
    n_checks++; if (zif.mem_rw_ !== 1'b1) begin n_fail++; $display("FAIL reset_mem_rw: got %0b expected 1", zif.mem_rw_); end
    n_checks++; if (zif.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h expected 0", zif.mem_addr); end
    n_checks++; if (zif.mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata: got %0h expected 0", zif.mem_wdata); end
    @(negedge clk);
    rst = 1'b0;
    feed_en = 1'b0;
    rdy = 1'b1;
    tick();
    n_checks++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0b expected 0", busy_s); end
  endtask

  task automatic test_stream();
    int done_at = -1;
    int done_cnt = 0;
    logic [AW+PW-1:0] g;
    seed = 0; feed_en = 1'b1; feed_n = 4; rdy = 1'b1;
    start_pass(4);
    for (int c = 0; c < 40 && done_at < 0; c++) begin
      tick();
      if (done_s) begin
        done_cnt++;
        done_at = c;
        n_checks++; if (busy_s !== 1'b1) begin n_fail++; $display("FAIL stream_busy_at_done: got %0b expected 1", busy_s); end
      end
    end
    n_checks++; if (done_at !== 9) begin n_fail++; $display("FAIL stream_done_cycle: got %0d expected 9", done_at); end
    tick();
    if (done_s) done_cnt++;
    n_checks++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL stream_busy_after: got %0b expected 0", busy_s); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL stream_done_count: got %0d expected 1", done_cnt); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= gnt_hist.size() || gnt_hist[i] !== ((i % 2 == 0) ? 1 : 2)) begin
        n_fail++;
        $display("FAIL stream_grant_%0d: got %0d expected %0d", i,
                 (i < gnt_hist.size()) ? gnt_hist[i] : -1, (i % 2 == 0) ? 1 : 2);
      end
    end
    n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL stream_out_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      void'(exp_q.pop_front());
      n_checks++;
      if (g !== {AW'(i), PW'(10 * (i + 1))}) begin
        n_fail++;
        $display("FAIL stream_out_%0d: got idx %0d data %0d expected idx %0d data %0d", i, g[AW+PW-1:PW], g[PW-1:0], i, 10 * (i + 1));
      end
    end
  endtask

  task automatic test_conflict();
    int done_at = -1;
    logic [AW+PW-1:0] g, e;
    seed = 5; feed_en = 1'b1; feed_n = 8; rdy = 1'b0;
    start_pass(8);
    for (int c = 0; c < 80 && done_at < 0; c++) begin
      rdy = (widx >= 4);
      start = (c == 3);
      num_queries = (c == 3) ? (AW+1)'(1) : (AW+1)'(8);
      tick();
      start = 1'b0;
      if (done_s) done_at = c;
    end
    n_checks++; if (done_at < 0) begin n_fail++; $display("FAIL conflict_timeout: got no done expected done"); end
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (5 + k >= gnt_hist.size() || gnt_hist[5+k] !== ((k % 2 == 0) ? 2 : 1)) begin
        n_fail++;
        $display("FAIL conflict_grant_%0d: got %0d expected %0d", 5 + k,
                 (5 + k < gnt_hist.size()) ? gnt_hist[5+k] : -1, (k % 2 == 0) ? 2 : 1);
      end
    end
    n_checks++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL conflict_out_count: got %0d expected 8", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL conflict_out: got %0h expected %0h", g, e); end
    end
  endtask

  task automatic test_backpressure();
    int hold = 0;
    int done_at = -1;
    logic [AW+PW-1:0] g, e;
    seed = 0; feed_en = 1'b1; feed_n = 3; rdy = 1'b1;
    start_pass(3);
    for (int c = 0; c < 60 && done_at < 0; c++) begin
      if (zif.rd_out_valid && hold < 5) begin
        rdy = 1'b0;
        hold++;
      end else begin
        rdy = 1'b1;
      end
      tick();
      if (!rdy) begin
        n_checks++; if (data_s !== 16'd10) begin n_fail++; $display("FAIL bp_hold_data: got %0d expected 10", data_s); end
        n_checks++; if (r_gnt !== 1'b0) begin n_fail++; $display("FAIL bp_read_while_full: got %0b expected 0", r_gnt); end
        if (hold == 5) begin
          n_checks++; if (widx !== 3) begin n_fail++; $display("FAIL bp_writes_done: got %0d expected 3", widx); end
        end
      end
      if (done_s) done_at = c;
    end
    n_checks++; if (done_at < 0) begin n_fail++; $display("FAIL bp_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL bp_out_count: got %0d expected 3", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL bp_out: got %0h expected %0h", g, e); end
    end
  endtask

  task automatic test_guard();
    int done_at = -1;
    logic [AW+PW-1:0] g, e;
    seed = 0; feed_en = 1'b1; feed_n = 1; rdy = 1'b1;
    start_pass(2);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c >= 2) begin
        n_checks++; if (rw_s !== 1'b1) begin n_fail++; $display("FAIL guard_mem_rw: got %0b expected 1", rw_s); end
        n_checks++; if (r_gnt !== 1'b0) begin n_fail++; $display("FAIL guard_early_read: got %0b expected 0", r_gnt); end
      end
    end
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL guard_stall_count: got %0d expected 1", got_q.size()); end
    feed_n = 2;
    for (int c = 0; c < 30 && done_at < 0; c++) begin
      tick();
      if (done_s) done_at = c;
    end
    n_checks++; if (done_at < 0) begin n_fail++; $display("FAIL guard_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL guard_out_count: got %0d expected 2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL guard_out: got %0h expected %0h", g, e); end
    end
  endtask

  task automatic test_edge_n0();
    int done_at = -1;
    int wf = 0;
    seed = 0; feed_en = 1'b1; feed_n = 999; rdy = 1'b1;
    start_pass(0);
    for (int c = 0; c < 10 && done_at < 0; c++) begin
      tick();
      if (w_fire) wf++;
      if (done_s) done_at = c;
    end
    n_checks++; if (done_at !== 1) begin n_fail++; $display("FAIL n0_done_cycle: got %0d expected 1", done_at); end
    n_checks++; if (wf !== 0) begin n_fail++; $display("FAIL n0_writes: got %0d expected 0", wf); end
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL n0_reads: got %0d expected 0", got_q.size()); end
  endtask

  task automatic test_edge_max();
    int done_at = -1;
    logic [AW+PW-1:0] g, e;
    seed = 3; feed_en = 1'b1; feed_n = 400; rdy = 1'b1;
    start_pass(300);
    for (int c = 0; c < 1200 && done_at < 0; c++) begin
      tick();
      if (done_s) done_at = c;
    end
    n_checks++; if (done_at < 0) begin n_fail++; $display("FAIL max_timeout: got no done expected done"); end
    n_checks++; if (widx !== MAXQ) begin n_fail++; $display("FAIL max_writes: got %0d expected %0d", widx, MAXQ); end
    tick();
    n_checks++; if (w_fire !== 1'b0) begin n_fail++; $display("FAIL max_wr_ready_after: got %0b expected 0", w_fire); end
    n_checks++; if (got_q.size() !== MAXQ) begin n_fail++; $display("FAIL max_out_count: got %0d expected %0d", got_q.size(), MAXQ); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL max_out: got %0h expected %0h", g, e); end
    end
  endtask

  task automatic test_async_reset();
    int done_at = -1;
    int dn = 0;
    logic [AW+PW-1:0] g, e;
    seed = 0; feed_en = 1'b1; feed_n = 4; rdy = 1'b1;
    start_pass(4);
    for (int c = 0; c < 20 && widx < 2; c++) tick();
    n_checks++; if (widx !== 2) begin n_fail++; $display("FAIL arst_setup: got %0d expected 2", widx); end
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %0b expected 0", busy); end
    n_checks++; if (zif.rd_out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b expected 0", zif.rd_out_valid); end
    n_checks++; if (zif.rd_out_data !== '0) begin n_fail++; $display("FAIL arst_data: got %0h expected 0", zif.rd_out_data); end
    n_checks++; if (zif.wr_ready !== 1'b0) begin n_fail++; $display("FAIL arst_wr_ready: got %0b expected 0", zif.wr_ready); end
    n_checks++; if (zif.mem_rw_ !== 1'b1) begin n_fail++; $display("FAIL arst_mem_rw: got %0b expected 1", zif.mem_rw_); end
    n_checks++; if (zif.mem_addr !== '0) begin n_fail++; $display("FAIL arst_mem_addr: got %0h expected 0", zif.mem_addr); end
    @(negedge clk);
    rst = 1'b0;
    feed_en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done_s || busy_s) dn++;
    end
    n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL arst_no_done: got %0d expected 0", dn); end
    feed_en = 1'b1; feed_n = 2;
    start_pass(2);
    for (int c = 0; c < 30 && done_at < 0; c++) begin
      tick();
      if (done_s) done_at = c;
    end
    n_checks++; if (done_at < 0) begin n_fail++; $display("FAIL arst_rerun_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL arst_rerun_count: got %0d expected 2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL arst_rerun_out: got %0h expected %0h", g, e); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    feed_en = 1'b0;
    feed_n  = 0;
    rdy     = 1'b1;
    seed    = 0;
    widx    = 0;
    zif.wr_valid = 1'b0;
    zif.wr_data = '0;
    zif.rd_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_conflict();
    test_backpressure();
    test_guard();
    test_edge_n0();
    test_edge_max();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/z_mem_sched.md
Name: z_mem_sched

Overview:
- Single-port access scheduler for the Z_j store (PROD_WIDTH x MAX_NUM_QUERIES, 1=READ / 0=WRITE select, combinational read, synchronous write).
- Shares the one memory port between two clients:
  - the MAC accumulation stage, which writes Z_j in query order;
  - the downstream normalisation stage, which consumes Z_j in order via a valid/ready output register.
- Sequences one pass of N queries per start, blocks reads of not-yet-written entries, and round-robins on conflict.

Parameters:
- PROD_WIDTH, 16, width of a Z_j word.
- MAX_NUM_QUERIES, 256, memory depth.
- ADDR_WIDTH, $clog2(MAX_NUM_QUERIES), memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin a pass (ignored unless IDLE)
- num_queries  in  ADDR_WIDTH+1  N for the pass, sampled on accepted start
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at pass completion
- wr_valid  in  1  writer has Z_j
- wr_data  in  PROD_WIDTH  Z_j value
- wr_ready  out  1  write granted this cycle
- rd_out_valid  out  1  output register holds a Z_j
- rd_out_data  out  PROD_WIDTH  Z_j value
- rd_out_idx  out  ADDR_WIDTH  query index of rd_out_data
- rd_out_ready  in  1  consumer accepts
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  PROD_WIDTH  memory write data
- mem_rw_  out  1  1=READ, 0=WRITE
- mem_rdata  in  PROD_WIDTH  memory combinational read data

Behaviour:
- Reset:
  - busy=0, done=0, rd_out_valid=0, rd_out_data=0, rd_out_idx=0, wr_ready=0.
  - mem_rw_=1, mem_addr=0, mem_wdata=0.
  - wr_ptr=rd_ptr=0, n_reg=0, last_grant=READ, FSM=IDLE.
  - Memory contents are not touched by this block.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: on start, load n_reg = min(num_queries, MAX_NUM_QUERIES), clear pointers, go to RUN. busy=1 from the next cycle.
  - RUN:
    - wr_elig = wr_valid && wr_ptr<n_reg.
    - rd_elig = rd_ptr<wr_ptr && (!rd_out_valid || rd_out_ready).
    - One grant per cycle, combinational.
  - RUN -> DONE when wr_ptr==n_reg, rd_ptr==n_reg, and the output register has drained (rd_out_valid=0 or being accepted).
  - DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0.
- Arbitration:
  - Only one client eligible: grant it.
  - Both eligible: grant the opposite of last_grant.
  - last_grant updates on every grant.
- Write grant:
  - wr_ready=1, mem_rw_=0, mem_addr=wr_ptr[ADDR_WIDTH-1:0], mem_wdata=wr_data.
  - Write lands at this posedge; wr_ptr++.
- Read grant:
  - mem_rw_=1, mem_addr=rd_ptr.
  - mem_rdata is captured into rd_out_data this posedge; rd_out_idx=rd_ptr; rd_out_valid=1 next cycle; rd_ptr++.
  - Latency from the write's posedge to rd_out_valid is at least 2 cycles.
- Output register: holds value while rd_out_valid && !rd_out_ready. Accept and refill in the same cycle is allowed (full throughput, no bubble).
- No grant: mem_rw_=1, mem_addr=rd_ptr, mem_wdata=0, wr_ready=0.
- wr_ready is never 1 outside RUN or when wr_ptr==n_reg.
- N=0: RUN exits immediately; done pulses 2 cycles after start, with zero memory ops.
- start while busy: ignored.
- rst mid-pass: everything returns to reset values immediately (asynchronous); the partial pass is abandoned with no done pulse.
- Pointers are ADDR_WIDTH+1 bits, so N=MAX_NUM_QUERIES compares correctly with no wrap.

Decomposition:
- Package z_sched_pkg: FSM state enum (IDLE, RUN, DONE) and grant enum (GNT_NONE, GNT_WR, GNT_RD).
- Natural sub-module: z_rr_arb2, a 2-requester round-robin arbiter holding last_grant.
- Memory instance lives outside; this block drives its port only.

Test Plan:
- N=4, writer streams 10,20,30,40 back-to-back, rd_out_ready=1:
  - writes granted on alternating cycles with reads after the first write;
  - outputs (idx,data) (0,10),(1,20),(2,30),(3,40) in order;
  - done pulses exactly once; busy falls the cycle after done.
- Conflict: wr_valid held high with reads eligible every cycle -> grants strictly alternate WR,RD,WR,RD; neither client starves.
- Backpressure: N=3, rd_out_ready=0 for 5 cycles after the first output:
  - rd_out_data stays 10;
  - no read grants while the register is full;
  - all writes still complete;
  - remaining outputs follow on release.
- Read-before-write guard: wr_valid low after one write -> rd_ptr stalls at 1, mem_rw_ stays 1, no rd_out_valid for index 1 until the second write lands.
- Edge N: N=0 -> done 2 cycles after start, no wr_ready. num_queries=300 with MAX=256 -> exactly 256 writes accepted; wr_ready=0 afterwards.
- Async rst asserted mid-pass (wr_ptr=2): outputs return to reset values before the next clk edge; no done; a new start then runs a clean pass.
